// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving the data-memory port through an IDLE/ACCESS/DONE FSM.
// Accepts one request per handshake and returns extended load data with a fault flag.
module mem_stage_lsu #(
    parameter int XLEN = 32,
    parameter int TIMEOUT_CYC = 0,
    parameter int RD_W = 5,
    localparam int NB = XLEN / 8,
    localparam int OFS = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [RD_W-1:0] resp_rd,
    output logic            resp_fault,
    output logic            mem_read,
    output logic            mem_write,
    output logic [NB-1:0]   mem_mbe,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_resp,
    input  logic [XLEN-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_n;
    logic [31:0] cnt;
    logic [1:0] lg, lg_q;
    logic uns_q, legal, misal, ok, timeout;
    logic [OFS-1:0] ofs, ofs_q;
    logic [NB-1:0] lmask;
    logic [6:0] sh;
    logic [XLEN-1:0] shifted, v, ext;
    logic signed [XLEN-1:0] sv;
    assign lg = req_funct3[1:0];
    assign ofs = req_addr[OFS-1:0];
    assign req_ready = state == IDLE;
    assign resp_valid = state == DONE;
    always_comb begin
        legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                (XLEN == 64 && req_funct3 inside {3'b011, 3'b110});
        misal = |(ofs & OFS'((32'd1 << lg) - 32'd1));
        ok = legal && !misal;
        lmask = lg == 2'd0 ? NB'(1) : lg == 2'd1 ? NB'(3) : lg == 2'd2 ? NB'(15) : NB'(255);
        timeout = TIMEOUT_CYC != 0 && cnt == 32'(TIMEOUT_CYC - 1);
        state_n = state == IDLE   ? (req_valid ? (ok ? ACCESS : DONE) : IDLE) :
                  state == ACCESS ? (mem_resp || timeout ? DONE : ACCESS) :
                  state == DONE   ? (resp_ready ? IDLE : DONE) : IDLE;
    end
    // Extension by shifting the field to the top, then back down logically or arithmetically.
    always_comb begin
        shifted = mem_rdata >> {ofs_q, 3'b000};
        sh = 7'(XLEN) - (7'd8 << lg_q);
        v = shifted << sh;
        sv = $signed(v) >>> sh;
        ext = uns_q ? v >> sh : $unsigned(sv);
    end
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            lg_q <= '0;
            uns_q <= 1'b0;
            ofs_q <= '0;
            resp_rdata <= '0;
            resp_rd <= '0;
            resp_fault <= 1'b0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_mbe <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE && req_valid) begin
            cnt <= '0;
            lg_q <= lg;
            uns_q <= req_funct3[2];
            ofs_q <= ofs;
            resp_rdata <= '0;
            resp_rd <= req_rd;
            resp_fault <= !ok;
            mem_read <= ok && !req_write;
            mem_write <= ok && req_write;
            mem_mbe <= req_write ? lmask << ofs : '0;
            mem_addr <= {req_addr[XLEN-1:OFS], {OFS{1'b0}}};
            mem_wdata <= req_write ? req_wdata << {ofs, 3'b000} : '0;
        end else if (state == ACCESS) begin
            cnt <= cnt + 32'd1;
            if (mem_resp || timeout) begin
                mem_read <= 1'b0;
                mem_write <= 1'b0;
                resp_fault <= !mem_resp;
                resp_rdata <= mem_resp && mem_read ? ext : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed checks of a 32-bit (timeout 8) and a 64-bit (no timeout) mem_stage_lsu.
module tb_mem_stage_lsu;
    logic clk = 0, rst = 0;
    logic req_valid = 0, req_write = 0, resp_ready = 1, mem_resp = 0;
    logic [2:0] req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic [4:0] req_rd = 0;
    logic req_ready, resp_valid, resp_fault, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [4:0] resp_rd;
    logic [3:0] mem_mbe;
    logic w_req_valid = 0, w_mem_resp = 0;
    logic [2:0] w_req_funct3 = 0;
    logic [63:0] w_req_addr = 0, w_req_wdata = 0, w_mem_rdata = 0;
    logic w_req_ready, w_resp_valid, w_resp_fault, w_mem_read, w_mem_write;
    logic [63:0] w_resp_rdata, w_mem_addr, w_mem_wdata;
    logic [4:0] w_resp_rd;
    logic [7:0] w_mem_mbe;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYC(8), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_fault(resp_fault), .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata));

    mem_stage_lsu #(.XLEN(64), .TIMEOUT_CYC(0), .RD_W(5)) dut64 (
        .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(req_write),
        .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_rd(req_rd),
        .resp_valid(w_resp_valid), .resp_ready(resp_ready), .resp_rdata(w_resp_rdata), .resp_rd(w_resp_rd),
        .resp_fault(w_resp_fault), .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_mbe(w_mem_mbe),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_resp(w_mem_resp), .mem_rdata(w_mem_rdata));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_rd = rd; req_valid = 1;
        step;
        req_valid = 0;
    endtask

    task automatic pulse_resp(input logic [31:0] d);
        mem_rdata = d; mem_resp = 1;
        step;
        mem_resp = 0;
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) step;
        rst = 1;
        step;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobe: got %b want 00", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 32'h0 || mem_mbe !== 4'h0) begin n_err++; $display("FAIL reset_mem: got %h/%b want 0/0000", mem_addr, mem_mbe); end
    endtask

    task automatic test_lb_wait;
        send(0, 3'b000, 32'h1003, 0, 5'd5);
        n_cmp++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin n_err++; $display("FAIL lb_strobe: got r%b w%b want r1 w0", mem_read, mem_write); end
        n_cmp++; if (mem_addr !== 32'h1000) begin n_err++; $display("FAIL lb_addr: got %h want 00001000", mem_addr); end
        n_cmp++; if (mem_mbe !== 4'b0000) begin n_err++; $display("FAIL lb_mbe: got %b want 0000", mem_mbe); end
        repeat (3) step;
        n_cmp++; if (resp_valid !== 1'b0 || mem_read !== 1'b1) begin n_err++; $display("FAIL lb_wait: got v%b r%b want v0 r1", resp_valid, mem_read); end
        pulse_resp(32'h80123456);
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL lb_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_rdata: got %h want ffffff80", resp_rdata); end
        n_cmp++; if (resp_fault !== 1'b0 || resp_rd !== 5'd5) begin n_err++; $display("FAIL lb_fault_rd: got %b/%0d want 0/5", resp_fault, resp_rd); end
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL lb_drop: got %b want 0", mem_read); end
        step;
    endtask

    task automatic test_loads;
        logic [2:0] f3 [4] = '{3'b001, 3'b101, 3'b100, 3'b010};
        logic [31:0] ad [4] = '{32'h1002, 32'h1002, 32'h1001, 32'h1000};
        logic [31:0] rd [4] = '{32'h80010000, 32'hABCD0000, 32'h00008000, 32'hDEADBEEF};
        logic [31:0] ex [4] = '{32'hFFFF8001, 32'h0000ABCD, 32'h00000080, 32'hDEADBEEF};
        for (int i = 0; i < 4; i++) begin
            send(0, f3[i], ad[i], 0, 5'(i));
            pulse_resp(rd[i]);
            n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== ex[i] || resp_fault !== 1'b0)
                begin n_err++; $display("FAIL load%0d: got v%b %h f%b want v1 %h f0", i, resp_valid, resp_rdata, resp_fault, ex[i]); end
            step;
        end
    endtask

    task automatic test_sh;
        send(1, 3'b001, 32'h1002, 32'h0000BEEF, 5'd3);
        n_cmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_err++; $display("FAIL sh_strobe: got w%b r%b want w1 r0", mem_write, mem_read); end
        n_cmp++; if (mem_mbe !== 4'b1100) begin n_err++; $display("FAIL sh_mbe: got %b want 1100", mem_mbe); end
        n_cmp++; if (mem_wdata[31:16] !== 16'hBEEF) begin n_err++; $display("FAIL sh_wdata: got %h want beef", mem_wdata[31:16]); end
        n_cmp++; if (mem_addr !== 32'h1000) begin n_err++; $display("FAIL sh_addr: got %h want 00001000", mem_addr); end
        step;
        n_cmp++; if (resp_valid !== 1'b0 || mem_write !== 1'b1) begin n_err++; $display("FAIL sh_wait: got v%b w%b want v0 w1", resp_valid, mem_write); end
        pulse_resp(32'hFFFFFFFF);
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_fault !== 1'b0 || mem_write !== 1'b0)
            begin n_err++; $display("FAIL sh_resp: got v%b %h f%b w%b want v1 0 f0 w0", resp_valid, resp_rdata, resp_fault, mem_write); end
        step;
    endtask

    task automatic test_faults;
        logic [2:0] f3 [3] = '{3'b010, 3'b111, 3'b110};
        logic [31:0] ad [3] = '{32'h1002, 32'h1000, 32'h1000};
        for (int i = 0; i < 3; i++) begin
            send(0, f3[i], ad[i], 0, 5'd7);
            n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_rdata !== 32'h0)
                begin n_err++; $display("FAIL fault%0d: got v%b f%b %h want v1 f1 0", i, resp_valid, resp_fault, resp_rdata); end
            n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL fault%0d_strobe: got %b want 00", i, {mem_read, mem_write}); end
            step;
        end
    endtask

    task automatic test_timeout;
        int hi = 0;
        send(0, 3'b010, 32'h2000, 0, 5'd1);
        while (mem_read && hi < 20) begin hi++; step; end
        n_cmp++; if (hi !== 8) begin n_err++; $display("FAIL timeout_len: got %0d want 8", hi); end
        n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_rdata !== 32'h0)
            begin n_err++; $display("FAIL timeout_resp: got v%b f%b %h want v1 f1 0", resp_valid, resp_fault, resp_rdata); end
        step;
    endtask

    task automatic test_back_to_back;
        resp_ready = 0;
        send(0, 3'b101, 32'h1002, 0, 5'd9);
        pulse_resp(32'hABCD0000);
        req_write = 0; req_funct3 = 3'b000; req_addr = 32'h1000; req_rd = 5'd4; req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000ABCD || resp_rd !== 5'd9 || req_ready !== 1'b0)
                begin n_err++; $display("FAIL stall%0d: got v%b %h rd%0d rdy%b want v1 0000abcd rd9 rdy0", i, resp_valid, resp_rdata, resp_rd, req_ready); end
            step;
        end
        resp_ready = 1;
        step;
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got v%b rdy%b want v0 rdy1", resp_valid, req_ready); end
        step;
        req_valid = 0;
        n_cmp++; if (mem_read !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got r%b rdy%b want r1 rdy0", mem_read, req_ready); end
        pulse_resp(32'h0000007F);
        n_cmp++; if (resp_rdata !== 32'h0000007F || resp_rd !== 5'd4) begin n_err++; $display("FAIL b2b_rdata: got %h rd%0d want 0000007f rd4", resp_rdata, resp_rd); end
        step;
    endtask

    task automatic test_reset_mid;
        send(0, 3'b010, 32'h3000, 0, 5'd2);
        rst = 0;
        step;
        rst = 1;
        n_cmp++; if (mem_read !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1)
            begin n_err++; $display("FAIL rst_mid: got r%b v%b rdy%b want r0 v0 rdy1", mem_read, resp_valid, req_ready); end
        step;
        pulse_resp(32'h12345678);
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL stray_resp: got v%b rdy%b want v0 rdy1", resp_valid, req_ready); end
    endtask

    task automatic test_xlen64;
        logic [2:0] f3 [3] = '{3'b110, 3'b010, 3'b011};
        logic [63:0] ad [3] = '{64'h1004, 64'h1004, 64'h1008};
        logic [63:0] ex [3] = '{64'h0000000080000001, 64'hFFFFFFFF80000001, 64'h8000000100000000};
        for (int i = 0; i < 3; i++) begin
            w_req_funct3 = f3[i]; w_req_addr = ad[i]; req_write = 0; w_req_valid = 1;
            step;
            w_req_valid = 0;
            n_cmp++; if (w_mem_read !== 1'b1 || w_mem_addr !== {ad[i][63:3], 3'b000})
                begin n_err++; $display("FAIL x64_%0d_addr: got r%b %h want r1 %h", i, w_mem_read, w_mem_addr, {ad[i][63:3], 3'b000}); end
            w_mem_rdata = 64'h80000001_00000000; w_mem_resp = 1;
            step;
            w_mem_resp = 0;
            n_cmp++; if (w_resp_valid !== 1'b1 || w_resp_rdata !== ex[i] || w_resp_fault !== 1'b0)
                begin n_err++; $display("FAIL x64_%0d: got v%b %h f%b want v1 %h f0", i, w_resp_valid, w_resp_rdata, w_resp_fault, ex[i]); end
            step;
        end
    endtask

    initial begin
        test_reset;
        test_lb_wait;
        test_loads;
        test_sh;
        test_faults;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_xlen64;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
